// File: rtl/mem_arb_pkg.sv
// Shared encodings and defaults for the CPU/DMA memory bus arbiter.
package mem_arb_pkg;

    localparam int unsigned ADDR_W_DEF        = 16;
    localparam int unsigned DATA_W_DEF        = 8;
    localparam int unsigned STARVE_LIMIT_DEF  = 8;
    localparam int unsigned MAX_DMA_BURST_DEF = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_CPU  = 2'b01,
        OWN_DMA  = 2'b10
    } owner_e;

    typedef enum logic {
        ST_CPU_PRI = 1'b0,
        ST_DMA_PRI = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic   valid;
        owner_e owner;
        logic   is_read;
    } ret_stage_t;

endpackage

// File: rtl/arb_return_pipe.sv
// Two-stage return tracker: follows each accepted access to the cycle its
// read data appears and steers that data to the owning requester.
module arb_return_pipe
    import mem_arb_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_accept,
    input  logic [1:0]        i_owner,
    input  logic              i_is_read,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_cpu_rvalid,
    output logic [DATA_W-1:0] o_cpu_rdata,
    output logic              o_dma_rvalid,
    output logic [DATA_W-1:0] o_dma_rdata
);

    ret_stage_t r_s1;
    ret_stage_t r_s2;
    logic       w_cpu_rv;
    logic       w_dma_rv;

    // Reset drops anything in flight so no stale read is ever returned.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1.valid   <= i_accept;
            r_s1.owner   <= owner_e'(i_owner);
            r_s1.is_read <= i_is_read;
            r_s2         <= r_s1;
        end
    end

    assign w_cpu_rv = r_s2.valid && r_s2.is_read && (r_s2.owner == OWN_CPU);
    assign w_dma_rv = r_s2.valid && r_s2.is_read && (r_s2.owner == OWN_DMA);

    assign o_cpu_rvalid = w_cpu_rv;
    assign o_dma_rvalid = w_dma_rv;
    assign o_cpu_rdata  = w_cpu_rv ? i_mem_rdata : '0;
    assign o_dma_rdata  = w_dma_rv ? i_mem_rdata : '0;

endmodule

// File: rtl/mem_bus_arbiter.sv
// CPU/DMA arbiter for a single-port synchronous RAM: CPU-first per-cycle
// grants, with a bounded DMA burst once DMA has been refused long enough.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W        = ADDR_W_DEF,
    parameter int unsigned DATA_W        = DATA_W_DEF,
    parameter int unsigned STARVE_LIMIT  = STARVE_LIMIT_DEF,
    parameter int unsigned MAX_DMA_BURST = MAX_DMA_BURST_DEF
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_cpu_req,
    input  logic              i_cpu_we,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic [DATA_W-1:0] i_cpu_wdata,
    output logic              o_cpu_gnt,
    output logic              o_cpu_rvalid,
    output logic [DATA_W-1:0] o_cpu_rdata,
    input  logic              i_dma_req,
    input  logic              i_dma_we,
    input  logic [ADDR_W-1:0] i_dma_addr,
    input  logic [DATA_W-1:0] i_dma_wdata,
    output logic              o_dma_gnt,
    output logic              o_dma_rvalid,
    output logic [DATA_W-1:0] o_dma_rdata,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_we,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic [1:0]        o_owner_out
);

    localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned BURST_W  = $clog2(MAX_DMA_BURST + 1);

    arb_state_e          r_state;
    arb_state_e          w_state_nxt;
    logic [STARVE_W-1:0] r_starve;
    logic [STARVE_W-1:0] w_starve_nxt;
    logic [BURST_W-1:0]  r_burst;
    logic [BURST_W-1:0]  w_burst_nxt;
    logic                r_hold;
    logic                w_hold_nxt;

    logic                w_cpu_gnt;
    logic                w_dma_gnt;
    owner_e              w_owner;
    logic                w_is_read;

    logic [ADDR_W-1:0]   r_mem_addr;
    logic                r_mem_we;
    logic [DATA_W-1:0]   r_mem_wdata;
    owner_e              r_owner;

    // State register together with the starvation/burst bookkeeping.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= ST_CPU_PRI;
            r_starve <= '0;
            r_burst  <= '0;
            r_hold   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_starve <= w_starve_nxt;
            r_burst  <= w_burst_nxt;
            r_hold   <= w_hold_nxt;
        end
    end

    // Next state: r_hold forces one CPU_PRI cycle after every DMA burst.
    always_comb begin
        w_state_nxt  = r_state;
        w_starve_nxt = r_starve;
        w_burst_nxt  = r_burst;
        w_hold_nxt   = 1'b0;
        case (r_state)
            ST_CPU_PRI: begin
                if (i_dma_req && !w_dma_gnt) begin
                    if (r_starve != STARVE_W'(STARVE_LIMIT))
                        w_starve_nxt = r_starve + STARVE_W'(1);
                end else begin
                    w_starve_nxt = '0;
                end
                if (!r_hold && (w_starve_nxt == STARVE_W'(STARVE_LIMIT)))
                    w_state_nxt = ST_DMA_PRI;
            end
            ST_DMA_PRI: begin
                if (w_dma_gnt)
                    w_burst_nxt = r_burst + BURST_W'(1);
                if (!i_dma_req || (w_burst_nxt == BURST_W'(MAX_DMA_BURST))) begin
                    w_state_nxt  = ST_CPU_PRI;
                    w_starve_nxt = '0;
                    w_burst_nxt  = '0;
                    w_hold_nxt   = 1'b1;
                end
            end
            default: begin
                w_state_nxt  = ST_CPU_PRI;
                w_starve_nxt = '0;
                w_burst_nxt  = '0;
            end
        endcase
    end

    // Grant decode: priority side wins, the other only when the first is idle.
    always_comb begin
        w_cpu_gnt = 1'b0;
        w_dma_gnt = 1'b0;
        if (!i_reset) begin
            if (r_state == ST_DMA_PRI) begin
                w_dma_gnt = i_dma_req;
                w_cpu_gnt = i_cpu_req && !i_dma_req;
            end else begin
                w_cpu_gnt = i_cpu_req;
                w_dma_gnt = i_dma_req && !i_cpu_req;
            end
        end
    end

    assign w_owner   = w_cpu_gnt ? OWN_CPU : (w_dma_gnt ? OWN_DMA : OWN_NONE);
    assign w_is_read = w_cpu_gnt ? !i_cpu_we : !i_dma_we;

    // Memory command register; idle cycles keep the address and drop the strobe.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_mem_addr  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= '0;
            r_owner     <= OWN_NONE;
        end else if (w_cpu_gnt) begin
            r_mem_addr  <= i_cpu_addr;
            r_mem_we    <= i_cpu_we;
            r_mem_wdata <= i_cpu_wdata;
            r_owner     <= OWN_CPU;
        end else if (w_dma_gnt) begin
            r_mem_addr  <= i_dma_addr;
            r_mem_we    <= i_dma_we;
            r_mem_wdata <= i_dma_wdata;
            r_owner     <= OWN_DMA;
        end else begin
            r_mem_we    <= 1'b0;
            r_owner     <= OWN_NONE;
        end
    end

    arb_return_pipe #(
        .DATA_W (DATA_W)
    ) u_ret (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_accept     (w_cpu_gnt | w_dma_gnt),
        .i_owner      (w_owner),
        .i_is_read    (w_is_read),
        .i_mem_rdata  (i_mem_rdata),
        .o_cpu_rvalid (o_cpu_rvalid),
        .o_cpu_rdata  (o_cpu_rdata),
        .o_dma_rvalid (o_dma_rvalid),
        .o_dma_rdata  (o_dma_rdata)
    );

    assign o_cpu_gnt   = w_cpu_gnt;
    assign o_dma_gnt   = w_dma_gnt;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_we    = r_mem_we;
    assign o_mem_wdata = r_mem_wdata;
    assign o_owner_out = r_owner;

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one single-port synchronous RAM (1-cycle read latency) between the cpu_core bus and a DMA requester (loader/video fetch).
- Per-cycle req/gnt arbiter:
  - CPU has default priority.
  - DMA gets a bounded burst after a starvation limit.
- Registers the memory command and returns read data to the owning requester with fixed latency.
- Sits between cpu_core (addr/din) and the RAM/ROM array; the top level derives the cpu_core clock enable from cpu_gnt/cpu_rvalid.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 8, data width.
- STARVE_LIMIT, 8, consecutive cycles dma_req may be refused before DMA takes priority (1..255).
- MAX_DMA_BURST, 4, maximum consecutive DMA accepts while DMA holds priority (1..15).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- cpu_req  in  1  CPU access request
- cpu_we  in  1  1=write
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_gnt  out  1  CPU request accepted this cycle
- cpu_rvalid  out  1  cpu_rdata valid
- cpu_rdata  out  DATA_W  read data
- dma_req  in  1  DMA access request
- dma_we  in  1  1=write
- dma_addr  in  ADDR_W  DMA address
- dma_wdata  in  DATA_W  DMA write data
- dma_gnt  out  1  DMA request accepted this cycle
- dma_rvalid  out  1  dma_rdata valid
- dma_rdata  out  DATA_W  read data
- mem_addr  out  ADDR_W  registered RAM address
- mem_we  out  1  registered RAM write strobe
- mem_wdata  out  DATA_W  registered RAM write data
- mem_rdata  in  DATA_W  RAM read data, valid the cycle after address
- owner_out  out  2  debug: 00 none, 01 CPU, 10 DMA (owner of the current mem_* cycle)

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Handshake: a transfer occurs in cycle N when req && gnt. gnt is combinational from req and registered state. At most one gnt per cycle. Requesters hold req/we/addr/wdata stable until gnt. A new request may be accepted every cycle (back-to-back).
- Latency:
  - Accepted in N: mem_addr/mem_we/mem_wdata registered and driven in N+1 with owner_out set.
  - mem_rdata is valid in N+2.
  - For reads, the owner's rvalid=1 in N+2 and rdata=mem_rdata (passthrough, qualified).
  - Writes produce no rvalid.
- Idle memory cycle: mem_we=0, owner_out=00, mem_addr holds its last value.
- Arbitration FSM:
  - CPU_PRI:
    - cpu_req wins.
    - dma_req wins only if cpu_req=0.
    - starve_cnt increments each cycle dma_req=1 && !dma_gnt, and clears on dma_gnt or dma_req=0.
    - When starve_cnt reaches STARVE_LIMIT, go to DMA_PRI next cycle.
  - DMA_PRI:
    - dma_req wins; CPU wins only if dma_req=0.
    - burst_cnt increments per DMA accept.
    - Return to CPU_PRI after the MAX_DMA_BURST-th accept, or on any cycle with dma_req=0.
    - starve_cnt and burst_cnt clear on exit.
  - After DMA_PRI exits, CPU_PRI is held for at least one cycle, even if starve_cnt is already saturated. starve_cnt never wraps; it saturates.
- Simultaneous events: both requesting in CPU_PRI below the limit → CPU. Both requesting in DMA_PRI → DMA.
- Return pipeline: 2-stage shift of {valid, owner, is_read}. Stage 2 drives rvalid.
- Reset (values in the cycle after reset is sampled high):
  - FSM=CPU_PRI; starve_cnt=0, burst_cnt=0.
  - mem_addr=0, mem_we=0, mem_wdata=0, owner_out=00.
  - Pipeline cleared; cpu_rvalid=dma_rvalid=0.
  - cpu_gnt=dma_gnt=0 while reset=1.
  - In-flight reads are dropped, never returned.
- Width: the counters are log2-sized for their limits. Addresses and data pass unmodified.

Decomposition:
- Package mem_arb_pkg holds:
  - owner encoding (OWN_NONE=2'b00, OWN_CPU=2'b01, OWN_DMA=2'b10);
  - FSM state encoding (ST_CPU_PRI, ST_DMA_PRI);
  - default STARVE_LIMIT and MAX_DMA_BURST.
- Sub-module arb_return_pipe: the 2-stage {valid, owner, is_read} shift register plus rvalid/rdata steering, reused for future third-requester variants.

Test Plan:
- CPU-only read at 0x0001, RAM[1]=0x04 → cpu_gnt in N, mem_addr=0x0001 and owner_out=01 in N+1, cpu_rvalid=1 with cpu_rdata=0x04 in N+2; dma_rvalid stays 0.
- Back-to-back CPU reads 0x0000..0x0003 on consecutive cycles → four consecutive cpu_rvalid pulses in order with RAM contents; no bubbles.
- DMA write 0xAA@0x0100 with cpu_req=0 → dma_gnt in the same cycle, mem_we=1/mem_addr=0x0100/mem_wdata=0xAA next cycle, no rvalid; a subsequent CPU read of 0x0100 returns 0xAA.
- Starvation, both held high continuously (defaults):
  - CPU granted 8 cycles, then DMA granted exactly 4 consecutive cycles, then CPU for at least 1 cycle.
  - The pattern repeats.
- DMA_PRI with dma_req dropped after 2 accepts → FSM returns to CPU_PRI immediately and CPU is granted in the next cycle.
- Reset asserted one cycle after a CPU read is accepted → no cpu_rvalid, mem_we=0, owner_out=00, counters cleared; the first request after reset is CPU-priority.
